// File: rtl/bf16_dot_seq.sv
// bf16_dot_seq: sequences bf16 pairs through an external FMA into a running accumulator.
// Define BF16_DOT_ZERO_SKIP_EN to skip pairs whose product is zero (adds skip_pulse).
module bf16_dot_seq #(
  parameter int FMA_LATENCY = 0,
  parameter int CNT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] init_acc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_last,
  output logic [15:0] fma_operand_a,
  output logic [15:0] fma_operand_b,
  output logic [15:0] fma_operand_c,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
`ifdef BF16_DOT_ZERO_SKIP_EN
  output logic        skip_pulse,
`endif
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FEED, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] acc;
  logic [CNT_W-1:0] cnt;
  logic last_q, fire, cap, skip;
  assign in_ready = state == FEED;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign out_result = acc;
  assign fire = in_valid && in_ready;
  assign cap = state == EXEC && cnt == CNT_W'(FMA_LATENCY);
`ifdef BF16_DOT_ZERO_SKIP_EN
  // A zero/subnormal exponent means the product is flushed to zero, so the FMA would return acc.
  assign skip = fire && (in_a[14:7] == 8'd0 || in_b[14:7] == 8'd0);
  always_ff @(posedge clk)
    skip_pulse <= reset ? 1'b0 : skip;
`else
  assign skip = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? FEED : IDLE;
      FEED: state_nx = !fire ? FEED : !skip ? EXEC : in_last ? DONE : FEED;
      EXEC: state_nx = !cap ? EXEC : last_q ? DONE : FEED;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      out_flags <= '0;
      fma_operand_a <= '0;
      fma_operand_b <= '0;
      fma_operand_c <= '0;
      cnt <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc <= init_acc;
        out_flags <= '0;
      end
      if (fire && !skip) begin
        fma_operand_a <= in_a;
        fma_operand_b <= in_b;
        fma_operand_c <= acc;
        last_q <= in_last;
        cnt <= '0;
      end
      if (cap) begin
        acc <= fma_result;
        out_flags <= out_flags | fma_flags;
      end else if (state == EXEC) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bf16_dot_seq.sv
// tb_bf16_dot_seq: directed checks of bf16_dot_seq against a table-driven FMA stand-in.
module tb_bf16_dot_seq;
  localparam int LAT = 2;
  logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] init_acc = 0, in_a = 0, in_b = 0;
  logic in_ready, out_valid, busy;
  logic [15:0] opa, opb, opc, fma_result, out_result;
  logic [3:0] fma_flags, out_flags;
  logic skip_pulse;
  int checks = 0, failures = 0, cyc = 0, exec_cyc = 0, skips = 0;
  always #5 clk = ~clk;
  bf16_dot_seq #(.FMA_LATENCY(LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .init_acc(init_acc),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .fma_operand_a(opa), .fma_operand_b(opb), .fma_operand_c(opc),
    .fma_result(fma_result), .fma_flags(fma_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
`ifdef BF16_DOT_ZERO_SKIP_EN
    .skip_pulse(skip_pulse),
`endif
    .busy(busy));
`ifndef BF16_DOT_ZERO_SKIP_EN
  assign skip_pulse = 1'b0;
`endif
  // Stand-in FMA: known a*b+c triples; anything else yields NaN with invalid set.
  always_comb begin
    {fma_flags, fma_result} = {4'b1000, 16'h7FC0};
    case ({opa, opb, opc})
      {16'h3F80, 16'h4000, 16'h3F80}: {fma_flags, fma_result} = {4'b0000, 16'h4040};
      {16'h4000, 16'h4040, 16'h4040}: {fma_flags, fma_result} = {4'b0000, 16'h4110};
      {16'h4000, 16'h4000, 16'h0000}: {fma_flags, fma_result} = {4'b0000, 16'h4080};
      {16'h3F80, 16'h3F80, 16'h0000}: {fma_flags, fma_result} = {4'b0001, 16'h3F80};
      {16'h3F80, 16'h3F80, 16'h3F80}: {fma_flags, fma_result} = {4'b0000, 16'h4000};
      {16'h4000, 16'h4000, 16'h4000}: {fma_flags, fma_result} = {4'b0100, 16'h40C0};
      {16'h3F80, 16'h4000, 16'h4000}: {fma_flags, fma_result} = {4'b0000, 16'h4080};
      default: ;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset) begin
    if (busy && !in_ready && !out_valid) exec_cyc++;
    if (skip_pulse) skips++;
    if (in_ready && (out_valid || !busy)) chk("ready_outside_feed", 1, 0);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic begin_stream(input logic [15:0] init);
    start = 1;
    init_acc = init;
    step();
    start = 0;
    init_acc = 16'h4040;
  endtask
  task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last, input int gap);
    int n;
    for (int i = 0; i < gap; i++) step();
    in_a = a;
    in_b = b;
    in_last = last;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("handshake_timeout", 0, 1);
    step();
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    if (n == 50) chk("done_timeout", 0, 1);
  endtask
  task automatic finish_stream();
    out_ready = 1;
    step();
    out_ready = 0;
    chk("idle_after_done", busy, 0);
  endtask
  initial begin
    int t0, seen;
    step();
    step();
    reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ops", {opa, opb}, 0);
    chk("rst_result", {out_flags, out_result}, 0);
    // Two-pair dot product: 1 + 1*2 + 2*3 = 9
    begin_stream(16'h3F80);
    t0 = cyc;
    chk("feed_ready", in_ready, 1);
    send_pair(16'h3F80, 16'h4000, 0, 0);
    send_pair(16'h4000, 16'h4040, 1, 0);
    wait_done();
    chk("basic_latency", cyc - t0, 2 * (LAT + 2));
    chk("basic_result", out_result, 16'h4110);
    chk("basic_flags", out_flags, 0);
    finish_stream();
    // Single pair: EXEC length and operand_c from the accumulator
    begin_stream(16'h0000);
    exec_cyc = 0;
    send_pair(16'h4000, 16'h4000, 1, 0);
    chk("exec_opc", opc, 16'h0000);
    wait_done();
    chk("exec_cycles", exec_cyc, LAT + 1);
    chk("lat_result", out_result, 16'h4080);
    finish_stream();
    // Irregular valid, flags on pairs 1 and 3, output backpressure
    begin_stream(16'h0000);
    send_pair(16'h3F80, 16'h3F80, 0, $urandom_range(0, 3));
    send_pair(16'h3F80, 16'h3F80, 0, $urandom_range(1, 3));
    send_pair(16'h4000, 16'h4000, 1, $urandom_range(0, 3));
    wait_done();
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", {out_flags, out_result}, {4'b0101, 16'h40C0});
      step();
    end
    finish_stream();
    // Reset in the second EXEC cycle aborts
    begin_stream(16'h0000);
    send_pair(16'h4000, 16'h4000, 1, 0);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_ops", {opa, opb, opc}, 0);
    chk("abort_acc", out_result, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid || busy) seen = 1;
      step();
    end
    chk("abort_stays_idle", seen, 0);
    // start during FEED and DONE must not disturb the stream
    begin_stream(16'h4000);
    start = 1;
    step();
    step();
    start = 0;
    send_pair(16'h3F80, 16'h4000, 1, 0);
    wait_done();
    start = 1;
    step();
    chk("start_in_done_hold", out_valid, 1);
    chk("start_ignored_result", out_result, 16'h4080);
    out_ready = 1;
    step();
    start = 0;
    out_ready = 0;
    chk("start_on_exit_ignored", busy, 0);
`ifdef BF16_DOT_ZERO_SKIP_EN
    begin_stream(16'h3F80);
    exec_cyc = 0;
    skips = 0;
    send_pair(16'h0000, 16'h4000, 0, 0);
    send_pair(16'h3F80, 16'h3F80, 0, 0);
    send_pair(16'h4000, 16'h0001, 1, 0);
    wait_done();
    step();
    chk("skip_pulses", skips, 2);
    chk("skip_exec_cycles", exec_cyc, LAT + 1);
    chk("skip_result", out_result, 16'h4000);
    finish_stream();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
